// File: rtl/sysforled_timer_pkg.sv
// Shared register map and bit positions for the sysforled N-channel timer.
// Optional feature macro: SYSFORLED_TIMER_PRESCALER_EN (per-channel prescaler).
package sysforled_timer_pkg;

    // Per-channel word offsets (low three address bits)
    localparam logic [2:0] OFF_STATUS   = 3'd0;
    localparam logic [2:0] OFF_CONTROL  = 3'd1;
    localparam logic [2:0] OFF_PERIODL  = 3'd2;
    localparam logic [2:0] OFF_PERIODH  = 3'd3;
    localparam logic [2:0] OFF_SNAPL    = 3'd4;
    localparam logic [2:0] OFF_SNAPH    = 3'd5;
    localparam logic [2:0] OFF_PRESCALE = 3'd6;

    // CONTROL bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // STATUS bit positions
    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

endpackage

// File: rtl/sysforled_multi_timer_if.sv
// Avalon-MM slave bus bundle for the sysforled multi-channel timer.
// Optional feature macro: SYSFORLED_TIMER_PRESCALER_EN (no effect on this bundle).
interface sysforled_multi_timer_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;

    modport master (output address, output chipselect, output write_n, output writedata,
                    input readdata);
    modport slave  (input address, input chipselect, input write_n, input writedata,
                    output readdata);
endinterface

// File: rtl/sysforled_timer_channel.sv
// One timer channel: period, down-counter, run/timeout state, control and snapshot.
// Optional feature macro: SYSFORLED_TIMER_PRESCALER_EN adds a 16-bit tick prescaler.
module sysforled_timer_channel
    import sysforled_timer_pkg::*;
#(
    parameter int             CNT_W          = 32,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(32'h0007_A11F)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [2:0]  offset,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        irq,
    output logic        irq_nxt
);
    localparam int HI_W = CNT_W - 16;

    logic [CNT_W-1:0] period_r, period_nxt_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [CNT_W-1:0] snap_r, snap_nxt_s;
    logic [3:0]       ctrl_r, ctrl_nxt_s;
    logic             run_r, run_nxt_s;
    logic             to_r, to_nxt_s;
    logic             irq_r;
    logic             tick_s;
    logic             timeout_s;

    logic wr_status_s, wr_ctrl_s, wr_per_s, wr_snap_s, start_wr_s, stop_wr_s;

    assign wr_status_s = wr_en && (offset == OFF_STATUS);
    assign wr_ctrl_s   = wr_en && (offset == OFF_CONTROL);
    assign wr_per_s    = wr_en && ((offset == OFF_PERIODL) || (offset == OFF_PERIODH));
    assign wr_snap_s   = wr_en && ((offset == OFF_SNAPL) || (offset == OFF_SNAPH));
    assign start_wr_s  = wr_ctrl_s && wdata[CTRL_START];
    assign stop_wr_s   = wr_ctrl_s && wdata[CTRL_STOP];

`ifdef SYSFORLED_TIMER_PRESCALER_EN
    logic [15:0] presc_r, presc_nxt_s;
    logic [15:0] pcnt_r, pcnt_nxt_s;

    // Prescaler: terminal count gives a tick, reload on period write and on START
    always_comb begin
        tick_s      = (pcnt_r == 16'd0);
        presc_nxt_s = (wr_en && (offset == OFF_PRESCALE)) ? wdata : presc_r;
        if (wr_per_s || start_wr_s) begin
            pcnt_nxt_s = presc_nxt_s;
        end else if (run_r) begin
            pcnt_nxt_s = tick_s ? presc_r : (pcnt_r - 16'd1);
        end else begin
            pcnt_nxt_s = pcnt_r;
        end
    end

    // Prescaler registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= 16'd0;
            pcnt_r  <= 16'd0;
        end else begin
            presc_r <= presc_nxt_s;
            pcnt_r  <= pcnt_nxt_s;
        end
    end
`else
    // Without a prescaler every clock is a tick
    always_comb begin
        tick_s = 1'b1;
    end
`endif

    // Next-state logic for period, counter, run, timeout, control and snapshot
    always_comb begin
        period_nxt_s = period_r;
        if (wr_en && (offset == OFF_PERIODL)) begin
            period_nxt_s[15:0] = wdata;
        end else begin
            period_nxt_s[15:0] = period_r[15:0];
        end
        if (wr_en && (offset == OFF_PERIODH)) begin
            period_nxt_s[CNT_W-1:16] = wdata[HI_W-1:0];
        end else begin
            period_nxt_s[CNT_W-1:16] = period_r[CNT_W-1:16];
        end

        // A period write takes precedence over a coincident expiry
        timeout_s = run_r && tick_s && (count_r == {CNT_W{1'b0}}) && !wr_per_s;

        if (wr_per_s) begin
            count_nxt_s = period_nxt_s;
        end else if (run_r && tick_s) begin
            count_nxt_s = (count_r == {CNT_W{1'b0}}) ? period_r : (count_r - CNT_W'(1));
        end else begin
            count_nxt_s = count_r;
        end

        if (start_wr_s) begin
            run_nxt_s = 1'b1;
        end else if (stop_wr_s || wr_per_s) begin
            run_nxt_s = 1'b0;
        end else if (timeout_s && !ctrl_r[CTRL_CONT]) begin
            run_nxt_s = 1'b0;
        end else begin
            run_nxt_s = run_r;
        end

        // Expiry beats a coincident STATUS clear so no timeout is lost
        if (timeout_s) begin
            to_nxt_s = 1'b1;
        end else if (wr_status_s) begin
            to_nxt_s = 1'b0;
        end else begin
            to_nxt_s = to_r;
        end

        ctrl_nxt_s = wr_ctrl_s ? wdata[3:0] : ctrl_r;
        snap_nxt_s = wr_snap_s ? count_r : snap_r;
        irq_nxt    = to_nxt_s && ctrl_nxt_s[CTRL_ITO];
    end

    // Channel state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_r <= DEFAULT_PERIOD;
            count_r  <= DEFAULT_PERIOD;
            snap_r   <= {CNT_W{1'b0}};
            ctrl_r   <= 4'd0;
            run_r    <= 1'b0;
            to_r     <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            period_r <= period_nxt_s;
            count_r  <= count_nxt_s;
            snap_r   <= snap_nxt_s;
            ctrl_r   <= ctrl_nxt_s;
            run_r    <= run_nxt_s;
            to_r     <= to_nxt_s;
            irq_r    <= irq_nxt;
        end
    end

    assign irq = irq_r;

    // Register read mux for this channel
    always_comb begin
        rdata = 16'd0;
        case (offset)
            OFF_STATUS:   rdata = {14'd0, run_r, to_r};
            OFF_CONTROL:  rdata = {12'd0, ctrl_r};
            OFF_PERIODL:  rdata = period_r[15:0];
            OFF_PERIODH:  rdata = 16'(period_r[CNT_W-1:16]);
            OFF_SNAPL:    rdata = snap_r[15:0];
            OFF_SNAPH:    rdata = 16'(snap_r[CNT_W-1:16]);
`ifdef SYSFORLED_TIMER_PRESCALER_EN
            OFF_PRESCALE: rdata = presc_r;
`endif
            default:      rdata = 16'd0;
        endcase
    end

endmodule

// File: rtl/sysforled_multi_timer.sv
// N-channel Avalon-MM interval timer used as the LED subsystem tick source.
// Top level: channel decode, registered read data, OR-combined interrupt.
// Optional feature macro: SYSFORLED_TIMER_PRESCALER_EN (per-channel prescaler).
module sysforled_multi_timer
    import sysforled_timer_pkg::*;
#(
    parameter int          NUM_CH         = 2,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h0007_A11F,
    parameter int          ADDR_W         = $clog2(NUM_CH) + 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sysforled_multi_timer_if.slave bus,
    output logic                   irq,
    output logic [NUM_CH-1:0]      irq_vec
);
    logic [7:0]        ch_s;
    logic              wr_s;
    logic [15:0]       ch_rdata_s [NUM_CH];
    logic [NUM_CH-1:0] irq_nxt_s;
    logic [15:0]       rd_mux_s;
    logic [15:0]       readdata_r;
    logic              irq_r;

    assign ch_s = 8'(bus.address >> 3);
    assign wr_s = bus.chipselect && !bus.write_n;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sysforled_timer_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (CNT_W'(DEFAULT_PERIOD))
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr_s && (ch_s == 8'(i))),
            .offset  (bus.address[2:0]),
            .wdata   (bus.writedata),
            .rdata   (ch_rdata_s[i]),
            .irq     (irq_vec[i]),
            .irq_nxt (irq_nxt_s[i])
        );
    end

    // Select the addressed channel; nonexistent channels read as zero
    always_comb begin
        rd_mux_s = 16'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_mux_s = (ch_s == 8'(i)) ? ch_rdata_s[i] : rd_mux_s;
        end
    end

    // Registered read data and combined interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 16'd0;
            irq_r      <= 1'b0;
        end else begin
            readdata_r <= rd_mux_s;
            irq_r      <= |irq_nxt_s;
        end
    end

    assign bus.readdata = readdata_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_sysforled_multi_timer.sv
// Self-checking bench for sysforled_multi_timer (NUM_CH=2, CNT_W=32).
// Honors SYSFORLED_TIMER_PRESCALER_EN when defined.
module tb_sysforled_multi_timer;
    import sysforled_timer_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       irq;
    logic [1:0] irq_vec;

    sysforled_multi_timer_if #(.ADDR_W(4)) bus ();

    sysforled_multi_timer #(
        .NUM_CH(2), .CNT_W(32), .DEFAULT_PERIOD(32'h0007_A11F)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq), .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        int          ch;
        logic [2:0]  off;
        logic [15:0] data;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

`ifdef SYSFORLED_TIMER_PRESCALER_EN
    localparam logic [15:0] PRE_EXP = 16'h1234;
`else
    localparam logic [15:0] PRE_EXP = 16'h0000;
`endif

    function automatic void add(bit w, int ch, logic [2:0] off, logic [15:0] d, string n);
        vec_t v;
        v.is_wr = w; v.ch = ch; v.off = off; v.data = d; v.name = n;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the write lands on the following posedge
    task automatic wr(input int ch, input logic [2:0] off, input logic [15:0] d);
        bus.address    = 4'(ch * 8 + int'(off));
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string name, input int ch, input logic [2:0] off,
                          input logic [15:0] exp);
        bus.address    = 4'(ch * 8 + int'(off));
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.chipselect = 1'b0;
        chk(name, bus.readdata, exp_q.pop_front());
    endtask

    task automatic irq_chk(input string name, input logic exp);
        chk(name, 16'(irq), 16'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address = 4'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 16'd0;

        add(1'b0, 0, OFF_STATUS,   16'h0000, "rst_status");
        add(1'b0, 0, OFF_PERIODL,  16'hA11F, "rst_periodl");
        add(1'b0, 0, OFF_PERIODH,  16'h0007, "rst_periodh");
        add(1'b0, 0, OFF_CONTROL,  16'h0000, "rst_control");
        add(1'b0, 0, OFF_SNAPL,    16'h0000, "rst_snapl");
        add(1'b0, 0, OFF_SNAPH,    16'h0000, "rst_snaph");
        add(1'b0, 0, OFF_PRESCALE, 16'h0000, "rst_off6");
        add(1'b0, 0, 3'd7,         16'h0000, "rst_off7");
        add(1'b0, 1, OFF_PERIODL,  16'hA11F, "rst_ch1_periodl");
        add(1'b0, 1, OFF_PERIODH,  16'h0007, "rst_ch1_periodh");
        add(1'b1, 0, 3'd7,         16'hFFFF, "");
        add(1'b0, 0, 3'd7,         16'h0000, "off7_reads0");
        add(1'b1, 0, OFF_CONTROL,  16'h0002, "");
        add(1'b0, 0, OFF_CONTROL,  16'h0002, "ctrl_readback");
        add(1'b0, 0, OFF_STATUS,   16'h0000, "ctrl_no_start");
        add(1'b1, 0, OFF_PERIODL,  16'h5555, "");
        add(1'b0, 0, OFF_PERIODL,  16'h5555, "periodl_rb");
        add(1'b1, 0, OFF_PERIODH,  16'h00AA, "");
        add(1'b0, 0, OFF_PERIODH,  16'h00AA, "periodh_rb");
        add(1'b0, 1, OFF_PERIODL,  16'hA11F, "ch1_isolated");
        add(1'b1, 0, OFF_PRESCALE, 16'h1234, "");
        add(1'b0, 0, OFF_PRESCALE, PRE_EXP,  "off6_rb");
        add(1'b1, 0, OFF_PRESCALE, 16'h0000, "");
        add(1'b1, 0, OFF_CONTROL,  16'h0000, "");

        // Reset state
        step(3);
        chk("rst_irq", 16'(irq), 16'h0000);
        chk("rst_irq_vec", 16'(irq_vec), 16'h0000);
        reset_n = 1'b1;
        step(1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_wr) wr(tbl[i].ch, tbl[i].off, tbl[i].data);
            else rd_chk(tbl[i].name, tbl[i].ch, tbl[i].off, tbl[i].data);
        end

        // ch1 continuous, period 4: timeout every 5 clocks
        wr(1, OFF_PERIODH, 16'h0000);
        wr(1, OFF_PERIODL, 16'h0004);
        wr(1, OFF_CONTROL, 16'h0007);
        for (int k = 0; k < 5; k++) begin irq_chk("cont_irq_low", 1'b0); step(1); end
        irq_chk("cont_irq_rise", 1'b1);
        chk("cont_irq_vec", 16'(irq_vec), 16'h0002);
        wr(1, OFF_STATUS, 16'h0000);
        for (int k = 0; k < 4; k++) begin irq_chk("cont_irq_cleared", 1'b0); step(1); end
        irq_chk("cont_irq_again", 1'b1);
        step(4);
        wr(1, OFF_STATUS, 16'h0000);
        irq_chk("clr_vs_timeout_irq", 1'b1);
        rd_chk("clr_vs_timeout_status", 1, OFF_STATUS, 16'h0003);
        wr(1, OFF_CONTROL, 16'h0008);
        wr(1, OFF_STATUS, 16'h0000);
        rd_chk("stop_status", 1, OFF_STATUS, 16'h0000);
        wr(1, OFF_CONTROL, 16'h000C);
        rd_chk("start_wins_status", 1, OFF_STATUS, 16'h0002);
        rd_chk("start_wins_ctrl", 1, OFF_CONTROL, 16'h000C);
        wr(1, OFF_CONTROL, 16'h0008);
        wr(1, OFF_STATUS, 16'h0000);

        // ch0 one-shot, period 9: single timeout after 10 clocks
        wr(0, OFF_PERIODH, 16'h0000);
        wr(0, OFF_PERIODL, 16'h0009);
        wr(0, OFF_CONTROL, 16'h0005);
        for (int k = 0; k < 10; k++) begin irq_chk("oneshot_irq_low", 1'b0); step(1); end
        irq_chk("oneshot_irq_rise", 1'b1);
        chk("oneshot_irq_vec", 16'(irq_vec), 16'h0001);
        rd_chk("oneshot_status", 0, OFF_STATUS, 16'h0001);
        wr(0, OFF_SNAPL, 16'h0000);
        rd_chk("oneshot_reload_l", 0, OFF_SNAPL, 16'h0009);
        rd_chk("oneshot_reload_h", 0, OFF_SNAPH, 16'h0000);
        wr(0, OFF_STATUS, 16'h0000);
        step(12);
        irq_chk("oneshot_no_retrigger", 1'b0);

        // Coherent snapshot of a running counter, then stop/resume
        wr(0, OFF_PERIODH, 16'h0001);
        wr(0, OFF_PERIODL, 16'h2349);
        wr(0, OFF_CONTROL, 16'h0006);
        step(4);
        wr(0, OFF_SNAPL, 16'h0000);
        rd_chk("snap_l", 0, OFF_SNAPL, 16'h2345);
        rd_chk("snap_h", 0, OFF_SNAPH, 16'h0001);
        wr(0, OFF_CONTROL, 16'h0008);
        wr(0, OFF_SNAPL, 16'h0000);
        rd_chk("stop_snap", 0, OFF_SNAPL, 16'h2341);
        step(3);
        wr(0, OFF_SNAPH, 16'h0000);
        rd_chk("stop_held", 0, OFF_SNAPL, 16'h2341);
        wr(0, OFF_CONTROL, 16'h0006);
        wr(0, OFF_SNAPL, 16'h0000);
        wr(0, OFF_SNAPL, 16'h0000);
        rd_chk("resume_from_held", 0, OFF_SNAPL, 16'h2340);
        wr(0, OFF_CONTROL, 16'h0008);

        // Period 0 continuous: timeout every tick, period write stops the channel
        wr(0, OFF_PERIODL, 16'h0000);
        wr(0, OFF_PERIODH, 16'h0000);
        wr(0, OFF_CONTROL, 16'h0007);
        step(1);
        irq_chk("p0_irq", 1'b1);
        wr(0, OFF_STATUS, 16'h0000);
        irq_chk("p0_clear_loses", 1'b1);
        rd_chk("p0_status", 0, OFF_STATUS, 16'h0003);
        wr(0, OFF_PERIODL, 16'h0005);
        rd_chk("perwr_clears_run", 0, OFF_STATUS, 16'h0001);
        wr(0, OFF_CONTROL, 16'h0000);
        wr(0, OFF_STATUS, 16'h0000);
        irq_chk("p0_quiet", 1'b0);

`ifdef SYSFORLED_TIMER_PRESCALER_EN
        // PRESCALE 3, period 1: timeout every 8 clocks
        wr(1, OFF_PRESCALE, 16'h0003);
        wr(1, OFF_PERIODH, 16'h0000);
        wr(1, OFF_PERIODL, 16'h0001);
        wr(1, OFF_CONTROL, 16'h0007);
        for (int k = 0; k < 8; k++) begin irq_chk("presc_irq_low", 1'b0); step(1); end
        irq_chk("presc_irq_rise", 1'b1);
        wr(1, OFF_CONTROL, 16'h0008);
        wr(1, OFF_STATUS, 16'h0000);
`endif

        // Asynchronous reset while a channel is interrupting
        wr(1, OFF_PERIODH, 16'h0000);
        wr(1, OFF_PERIODL, 16'h0000);
        wr(1, OFF_CONTROL, 16'h0007);
        step(6);
        irq_chk("pre_reset_irq", 1'b1);
        #2 reset_n = 1'b0;
        #1;
        irq_chk("async_reset_irq", 1'b0);
        chk("async_reset_vec", 16'(irq_vec), 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        step(3);
        irq_chk("post_reset_irq", 1'b0);
        rd_chk("post_reset_periodl", 1, OFF_PERIODL, 16'hA11F);
        rd_chk("post_reset_status", 1, OFF_STATUS, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
